// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART RX config sequencer and frame FIFO (optional flush: UART_RX_CTRL_FLUSH_EN)
module uart_rx_ctrl #(
    parameter int data_width     = 8,
    parameter int prescale_width = 5,
    parameter int fifo_depth     = 4,
    parameter int settle_cycles  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_wr,
    input  logic [prescale_width-1:0] cfg_prescale,
    input  logic                      cfg_par_en,
    input  logic                      cfg_par_typ,
    output logic                      cfg_ack,
    output logic                      cfg_err,
    output logic                      cfg_pending,
    output logic [prescale_width-1:0] Prescale,
    output logic                      parity_enable,
    output logic                      par_typ,
    output logic                      rx_hold,
    input  logic                      rx_busy,
    input  logic                      rx_data_valid,
    input  logic [data_width-1:0]     rx_data,
    input  logic                      rx_frame_err,
    input  logic                      rd_en,
    output logic [data_width-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      empty,
    output logic                      full,
    output logic                      overrun,
    input  logic                      ovr_clr,
    output logic [7:0]                err_cnt
);
    localparam int aw = $clog2(fifo_depth);
    localparam int pw = aw + 1;
    localparam int cw = $clog2(settle_cycles + 1);

    typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_APPLY, ST_SETTLE} state_t;

    state_t                    state_q;
    logic [cw-1:0]             settle_q;
    logic [prescale_width-1:0] prescale_q, pend_pre_q, sel_pre;
    logic                      par_en_q, par_typ_q, pend_en_q, pend_typ_q, sel_en, sel_typ;
    logic                      pending_q, cfg_ack_q, cfg_err_q, rx_hold_q;
    logic                      cfg_legal, cfg_ok, apply_now;

    assign cfg_legal = (cfg_prescale == prescale_width'(8)) || (cfg_prescale == prescale_width'(16));
    assign cfg_ok    = cfg_wr && cfg_legal;

    // A request arriving in the same cycle as the apply beats the stored one
    assign sel_pre = cfg_ok ? cfg_prescale : pend_pre_q;
    assign sel_en  = cfg_ok ? cfg_par_en   : pend_en_q;
    assign sel_typ = cfg_ok ? cfg_par_typ  : pend_typ_q;

    assign apply_now = ((state_q == ST_RUN) && (cfg_ok || pending_q) && !rx_busy) ||
                       ((state_q == ST_WAIT) && !rx_busy && !rx_data_valid);

    // Config FSM: live settings change only on entry to APPLY, then hold the datapath to settle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            settle_q   <= '0;
            prescale_q <= prescale_width'(8);
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            pend_pre_q <= prescale_width'(8);
            pend_en_q  <= 1'b0;
            pend_typ_q <= 1'b0;
            pending_q  <= 1'b0;
            cfg_ack_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
            rx_hold_q  <= 1'b0;
        end else begin
            cfg_ack_q <= 1'b0;
            cfg_err_q <= cfg_wr && !cfg_legal;
            if (cfg_ok) begin
                pend_pre_q <= cfg_prescale;
                pend_en_q  <= cfg_par_en;
                pend_typ_q <= cfg_par_typ;
            end
            if (apply_now) begin
                prescale_q <= sel_pre;
                par_en_q   <= sel_en;
                par_typ_q  <= sel_typ;
                pending_q  <= 1'b0;
                cfg_ack_q  <= 1'b1;
                rx_hold_q  <= 1'b1;
                state_q    <= ST_APPLY;
            end else begin
                if (cfg_ok) begin
                    pending_q <= 1'b1;
                end
                case (state_q)
                    ST_RUN: begin
                        if (cfg_ok || pending_q) begin
                            state_q <= ST_WAIT;
                        end
                    end
                    ST_WAIT: state_q <= ST_WAIT;
                    ST_APPLY: begin
                        settle_q <= cw'(settle_cycles - 1);
                        state_q  <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (settle_q == '0) begin
                            rx_hold_q <= 1'b0;
                            state_q   <= ST_RUN;
                        end else begin
                            settle_q <= settle_q - 1'b1;
                        end
                    end
                    default: state_q <= ST_RUN;
                endcase
            end
        end
    end

    assign cfg_ack       = cfg_ack_q;
    assign cfg_err       = cfg_err_q;
    assign cfg_pending   = pending_q;
    assign Prescale      = prescale_q;
    assign parity_enable = par_en_q;
    assign par_typ       = par_typ_q;
    assign rx_hold       = rx_hold_q;

    logic [data_width-1:0] mem [fifo_depth];
    logic [pw-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [data_width-1:0] rd_data_q;
    logic                  rd_valid_q, overrun_q;
    logic [7:0]            err_cnt_q;
    logic                  empty_w, full_w, flush_now, pop, push, drop;

`ifdef UART_RX_CTRL_FLUSH_EN
    assign flush_now = (state_q == ST_APPLY);
`else
    assign flush_now = 1'b0;
`endif

    assign empty_w = (wptr_q == rptr_q);
    assign full_w  = (wptr_q[aw] != rptr_q[aw]) && (wptr_q[aw-1:0] == rptr_q[aw-1:0]);
    assign pop     = rd_en && !empty_w && !flush_now;
    assign push    = rx_data_valid && (!full_w || pop) && !flush_now;
    assign drop    = rx_data_valid && full_w && !pop && !flush_now;

    // Pointer next-state; a flush rewinds both pointers
    always_comb begin
        wptr_d = wptr_q + pw'(push);
        rptr_d = rptr_q + pw'(pop);
        if (flush_now) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    // FIFO storage has no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q[aw-1:0]] <= rx_data;
        end
    end

    // FIFO pointers, registered read port, sticky overrun and saturating error count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_valid_q <= pop;
            if (pop) begin
                rd_data_q <= mem[rptr_q[aw-1:0]];
            end
            if (flush_now) begin
                overrun_q <= 1'b0;
            end else if (drop) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end
            if (flush_now) begin
                err_cnt_q <= '0;
            end else if (rx_frame_err && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_w;
    assign full     = full_w;
    assign overrun  = overrun_q;
    assign err_cnt  = err_cnt_q;
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Configuration sequencer and frame buffer for the UART receive datapath (RX FSM, edge/bit counters, checkers, deserializer).
- Owns the live Prescale / parity settings and applies host updates only between frames, holding the datapath idle while they take effect.
- Buffers good frames in a small FIFO for the host and counts errored frames.

Parameters:
- data_width, 8, frame payload width.
- prescale_width, 5, width of the Prescale bus driven to the datapath.
- fifo_depth, 4, FIFO entries; power of two, at least 2.
- settle_cycles, 2, cycles rx_hold stays high after a config apply; at least 1.

Ports:
- clk  input  1  single clock for the block and the RX datapath.
- rst  input  1  asynchronous active-low reset.
- cfg_wr  input  1  one-cycle request to load new configuration.
- cfg_prescale  input  prescale_width  requested oversampling ratio.
- cfg_par_en  input  1  requested parity enable.
- cfg_par_typ  input  1  requested parity type: 0 even, 1 odd.
- cfg_ack  output  1  one-cycle pulse when a configuration is applied.
- cfg_err  output  1  one-cycle pulse when cfg_wr is rejected.
- cfg_pending  output  1  an accepted configuration is waiting to apply.
- Prescale  output  prescale_width  live prescale to the datapath.
- parity_enable  output  1  live parity enable to the datapath.
- par_typ  output  1  live parity type to the datapath.
- rx_hold  output  1  keeps the datapath FSM in IDLE while high.
- rx_busy  input  1  datapath frame in progress (FSM enable output).
- rx_data_valid  input  1  one-cycle pulse: good frame complete.
- rx_data  input  data_width  deserialized payload, valid with rx_data_valid.
- rx_frame_err  input  1  one-cycle pulse: frame ended with a parity or stop error.
- rd_en  input  1  host pop request.
- rd_data  output  data_width  popped byte, registered.
- rd_valid  output  1  rd_data valid; one-cycle pulse.
- empty  output  1  FIFO empty.
- full  output  1  FIFO full.
- overrun  output  1  sticky: a frame was dropped because the FIFO was full.
- ovr_clr  input  1  clears overrun.
- err_cnt  output  8  saturating count of errored frames.

Behaviour:
- Reset values:
  - Prescale=8, parity_enable=0, par_typ=0.
  - rx_hold=0, cfg_ack=0, cfg_err=0, cfg_pending=0.
  - rd_data=0, rd_valid=0, empty=1, full=0, overrun=0, err_cnt=0.
  - FSM in RUN; FIFO pointers cleared; any pending configuration discarded.
- Configuration legality: cfg_prescale must be 8 or 16.
  - Any other value: cfg_err pulses on the next cycle and nothing is stored.
  - A pending configuration is unaffected by a rejected request.
- FSM states: RUN, WAIT, APPLY, SETTLE.
- RUN:
  - Legal cfg_wr with rx_busy=0 goes to APPLY.
  - Legal cfg_wr with rx_busy=1 latches the request, sets cfg_pending and goes to WAIT.
- WAIT:
  - A new legal cfg_wr overwrites the pending values; latest wins.
  - Leave for APPLY on the first cycle with rx_busy=0 and rx_data_valid=0.
- APPLY (1 cycle):
  - Register the new values onto Prescale / parity_enable / par_typ.
  - rx_hold=1, cfg_ack=1, cfg_pending=0.
  - Go to SETTLE.
- SETTLE: rx_hold=1 for settle_cycles cycles via down-counter, then go to RUN.
- A cfg_wr arriving during APPLY or SETTLE is latched as pending and applied after returning to RUN.
- Live outputs change only in APPLY, so a frame never sees a mid-frame configuration change.
- FIFO:
  - rx_data_valid pushes rx_data.
  - Pop: rd_en with empty=0 gives rd_data / rd_valid one cycle later.
  - rd_en while empty is ignored; rd_valid=0 and rd_data holds.
- FIFO full cases:
  - Push while full with no pop: drop the data and set overrun.
  - Push and pop in the same cycle while full: both happen, overrun unchanged.
  - Push and pop in the same cycle while empty: a push only, no pass-through.
- Pointers are log2(fifo_depth)+1 bits and wrap naturally; full/empty are derived from the MSB compare.
- overrun: ovr_clr clears it; a drop in the same cycle as ovr_clr wins and overrun stays 1.
- err_cnt: increments on rx_frame_err and saturates at 255; it is never pushed into the FIFO.

Optional Feature:
- Macro: UART_RX_CTRL_FLUSH_EN.
- Defined: the APPLY cycle also clears the FIFO pointers, overrun and err_cnt.
  - A pop requested in that cycle is dropped.
  - empty=1 the cycle after APPLY.
- Undefined: FIFO contents, overrun and err_cnt survive reconfiguration.

Test Plan:
- Reset, then cfg_wr with prescale=16, par_en=1, typ=1 and rx_busy=0 -> cfg_ack the next cycle; Prescale=16, parity_enable=1, par_typ=1; rx_hold high 3 cycles total (APPLY + 2 SETTLE).
- cfg_wr with prescale=12 -> cfg_err pulse; Prescale stays 8; cfg_pending=0.
- rx_busy=1, cfg_wr prescale=16, then cfg_wr prescale=8 while still busy -> cfg_pending=1, no change while busy; after rx_busy falls, applies Prescale=8 (latest wins).
- Push 0xA5, 0x3C, 0xFF, 0x01 (full=1), push 0x77 -> overrun=1, 0x77 lost; four pops return A5, 3C, FF, 01 with rd_valid one cycle after each rd_en; then empty=1.
- Full FIFO with push 0x55 and pop in the same cycle -> overrun stays 0; the last pop sequence ends with 0x55.
- 300 rx_frame_err pulses -> err_cnt=255; with UART_RX_CTRL_FLUSH_EN defined, a subsequent config apply gives err_cnt=0 and empty=1.
